// File: rtl/cp0_timer_ext_if.sv
// cp0_timer_ext_if: signal bundle between the M stage and coprocessor 0.
interface cp0_timer_ext_if #(
    parameter int NUM_HWINT = 6
);
    logic [4:0]           i_rd_addr;
    logic [4:0]           i_wr_addr;
    logic [31:0]          i_wr_data;
    logic                 i_we;
    logic [31:0]          i_pc;
    logic [4:0]           i_exc_code;
    logic                 i_in_delay_slot;
    logic                 i_exl_clr;
    logic [NUM_HWINT-1:0] i_hw_int;
    logic                 o_req;
    logic [31:0]          o_epc_out;
    logic [31:0]          o_rd_data;
    logic                 o_timer_irq;

    modport slave (
        input  i_rd_addr, i_wr_addr, i_wr_data, i_we, i_pc, i_exc_code,
               i_in_delay_slot, i_exl_clr, i_hw_int,
        output o_req, o_epc_out, o_rd_data, o_timer_irq
    );

    modport master (
        output i_rd_addr, i_wr_addr, i_wr_data, i_we, i_pc, i_exc_code,
               i_in_delay_slot, i_exl_clr, i_hw_int,
        input  o_req, o_epc_out, o_rd_data, o_timer_irq
    );
endinterface

// File: rtl/cp0_timer_ext.sv
// cp0_timer_ext: MIPS coprocessor 0 (SR, Cause, EPC, PRId) with a Count/Compare timer.
module cp0_timer_ext #(
    parameter int          NUM_HWINT   = 6,
    parameter int          TIMER_EN    = 1,
    parameter int          COUNT_SHIFT = 0,
    parameter logic [31:0] PRID_VAL    = 32'h2003_1015
) (
    input logic            clk,
    input logic            reset,
    cp0_timer_ext_if.slave bus
);
    localparam int          PW        = (COUNT_SHIFT > 0) ? COUNT_SHIFT : 1;
    localparam logic [PW-1:0] P_ONE   = PW'(1);
    localparam logic [PW-1:0] P_MAX   = '1;
    localparam logic [4:0]  A_COUNT   = 5'd9;
    localparam logic [4:0]  A_COMPARE = 5'd11;
    localparam logic [4:0]  A_SR      = 5'd12;
    localparam logic [4:0]  A_CAUSE   = 5'd13;
    localparam logic [4:0]  A_EPC     = 5'd14;
    localparam logic [4:0]  A_PRID    = 5'd15;

    logic                 r_ie;
    logic                 r_exl;
    logic [NUM_HWINT-1:0] r_im;
    logic                 r_bd;
    logic                 r_ti;
    logic [NUM_HWINT-1:0] r_ip;
    logic [4:0]           r_exc_code;
    logic [31:0]          r_epc;
    logic [31:0]          r_count;
    logic [31:0]          r_compare;
    logic [PW-1:0]        r_presc;

    logic [NUM_HWINT-1:0] w_pend;
    logic                 w_int_req;
    logic                 w_exc_req;
    logic                 w_req;
    logic [31:0]          w_epc_out;
    logic [31:0]          w_sr;
    logic [31:0]          w_cause;
    logic                 w_wr;
    logic                 w_wr_sr;
    logic                 w_wr_epc;
    logic                 w_wr_count;
    logic                 w_wr_compare;
    logic                 w_tick;
    logic [PW-1:0]        w_presc_nxt;
    logic [31:0]          w_count_inc;
    logic                 w_timer_rd;

    // The timer interrupt shares the highest hardware line.
    always_comb begin
        w_pend = bus.i_hw_int;
        w_pend[NUM_HWINT-1] = bus.i_hw_int[NUM_HWINT-1] | (r_ti & (TIMER_EN != 0));
    end

    assign w_int_req = !r_exl & r_ie & (|(w_pend & r_im));
    assign w_exc_req = !r_exl & (bus.i_exc_code != 5'd0);
    assign w_req     = !reset & (w_int_req | w_exc_req);
    assign w_epc_out = w_req ? (bus.i_in_delay_slot ? bus.i_pc - 32'd4 : bus.i_pc) : r_epc;

    always_comb begin
        w_sr = 32'd0;
        w_sr[0] = r_ie;
        w_sr[1] = r_exl;
        w_sr[10 +: NUM_HWINT] = r_im;
    end

    always_comb begin
        w_cause = 32'd0;
        w_cause[31] = r_bd;
        w_cause[30] = r_ti;
        w_cause[10 +: NUM_HWINT] = r_ip;
        w_cause[6:2] = r_exc_code;
    end

    // A taken exception/interrupt swallows any mtc0 in the same cycle.
    assign w_wr         = !w_req & bus.i_we;
    assign w_wr_sr      = w_wr & (bus.i_wr_addr == A_SR);
    assign w_wr_epc     = w_wr & (bus.i_wr_addr == A_EPC);
    assign w_wr_count   = w_wr & (bus.i_wr_addr == A_COUNT);
    assign w_wr_compare = w_wr & (bus.i_wr_addr == A_COMPARE);

    assign w_tick      = (COUNT_SHIFT == 0) || (r_presc == P_MAX);
    assign w_presc_nxt = w_tick ? '0 : r_presc + P_ONE;
    assign w_count_inc = r_count + 32'd1;
    assign w_timer_rd  = (TIMER_EN != 0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ie       <= 1'b0;
            r_exl      <= 1'b0;
            r_im       <= '0;
            r_bd       <= 1'b0;
            r_ti       <= 1'b0;
            r_ip       <= '0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
            r_count    <= 32'd0;
            r_compare  <= 32'hFFFF_FFFF;
            r_presc    <= '0;
        end else begin
            r_ip <= w_pend;
            if (w_req) begin
                r_exc_code <= w_int_req ? 5'd0 : bus.i_exc_code;
                r_exl      <= 1'b1;
                r_epc      <= w_epc_out;
                r_bd       <= bus.i_in_delay_slot;
            end else begin
                if (bus.i_exl_clr)
                    r_exl <= 1'b0;
                if (w_wr_sr) begin
                    r_ie  <= bus.i_wr_data[0];
                    r_exl <= bus.i_wr_data[1];
                    r_im  <= bus.i_wr_data[10 +: NUM_HWINT];
                end
                if (w_wr_epc)
                    r_epc <= bus.i_wr_data;
            end
            if (TIMER_EN != 0) begin
                if (w_wr_count) begin
                    r_count <= bus.i_wr_data;
                    r_presc <= '0;
                end else begin
                    r_presc <= w_presc_nxt;
                    if (w_tick) begin
                        r_count <= w_count_inc;
                        if (w_count_inc == r_compare)
                            r_ti <= 1'b1;
                    end
                end
                if (w_wr_compare) begin
                    r_compare <= bus.i_wr_data;
                    r_ti      <= 1'b0;
                end
            end
        end
    end

    assign bus.o_req       = w_req;
    assign bus.o_epc_out   = w_epc_out;
    assign bus.o_timer_irq = r_ti;
    assign bus.o_rd_data   = (bus.i_rd_addr == A_SR)                   ? w_sr      :
                             (bus.i_rd_addr == A_CAUSE)                ? w_cause   :
                             (bus.i_rd_addr == A_EPC)                  ? r_epc     :
                             (bus.i_rd_addr == A_PRID)                 ? PRID_VAL  :
                             (bus.i_rd_addr == A_COUNT && w_timer_rd)   ? r_count   :
                             (bus.i_rd_addr == A_COMPARE && w_timer_rd) ? r_compare :
                             32'd0;
endmodule
